// File: rtl/mx_quant_fp6.sv
// Streaming MX block quantizer: buffers k signed integers, derives one shared power-of-two
// scale from the largest magnitude, then emits k FP6 (ExMy) elements carrying that scale.
module mx_quant_fp6 #(
    parameter int unsigned exp_width   = 2,
    parameter int unsigned man_width   = 3,
    parameter int unsigned k           = 32,
    parameter int unsigned in_width    = 16,
    parameter int unsigned elem_width  = 1 + exp_width + man_width,
    parameter int unsigned scale_width = $clog2(in_width) + 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [in_width-1:0]    i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [elem_width-1:0]  o_elem,
    output logic [scale_width-1:0] o_scale,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last
);

    localparam int          bias       = (1 << (exp_width - 1)) - 1;
    localparam int          emax       = (1 << exp_width) - 1 - bias;
    localparam int          max_field  = (1 << exp_width) - 1;
    localparam int unsigned mag_width  = in_width + 1;
    localparam int unsigned wide_width = 2 * mag_width;
    localparam int unsigned idx_width  = $clog2(k);
    localparam logic [idx_width-1:0] last_idx = idx_width'(k - 1);

    typedef enum logic [1:0] {StFill, StScale, StEmit} state_e;

    state_e                 state_q, state_d;
    logic [idx_width-1:0]   idx_q, idx_d;
    logic [mag_width-1:0]   acc_q, acc_d;
    logic [scale_width-1:0] scale_q, scale_d;
    logic [in_width-1:0]    data_q [k];
    logic                   wr_en;
    logic [mag_width-1:0]   in_mag;

    // Extra magnitude bit keeps -2^(in_width-1) exact.
    function automatic logic [mag_width-1:0] magnitude(input logic [in_width-1:0] x);
        logic [mag_width-1:0] ext;
        ext = {x[in_width-1], x};
        return x[in_width-1] ? (~ext + mag_width'(1)) : ext;
    endfunction

    function automatic int lead_one(input logic [mag_width-1:0] v);
        int pos;
        pos = 0;
        for (int i = 0; i < int'(mag_width); i++) begin
            if (v[i]) pos = i;
        end
        return pos;
    endfunction

    assign in_mag = magnitude(i_data);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        scale_d = scale_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            StFill: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    wr_en = 1'b1;
                    acc_d = acc_q | in_mag;
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = StScale;
                    end else begin
                        idx_d = idx_q + idx_width'(1);
                    end
                end
            end
            StScale: begin
                scale_d = (acc_q == '0) ? '0 : scale_width'(lead_one(acc_q) - emax);
                idx_d   = '0;
                state_d = StEmit;
            end
            StEmit: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = StFill;
                    end else begin
                        idx_d = idx_q + idx_width'(1);
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StFill;
            idx_q   <= '0;
            acc_q   <= '0;
            scale_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            scale_q <= scale_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) data_q[idx_q] <= i_data;
    end

    // Element encoder: align the magnitude so man_width+1 significant bits remain, where the
    // alignment point is the leading one (normal) or the subnormal floor, whichever is higher.
    logic [in_width-1:0]   cur;
    logic [mag_width-1:0]  cur_mag;
    int                    s_int, p, sub_e, e_eff, sh, fld;
    logic [wide_width-1:0] wide, q, rem, half, rnd_full;
    logic [man_width+1:0]  rnd;
    logic [man_width-1:0]  man;
    logic                  nonzero;
    logic [elem_width-1:0] enc;
    logic                  unused_rnd;

    always_comb begin
        cur      = data_q[idx_q];
        cur_mag  = magnitude(cur);
        s_int    = int'($signed(scale_q));
        p        = lead_one(cur_mag);
        sub_e    = s_int + 1 - bias;
        e_eff    = (p > sub_e) ? p : sub_e;
        sh       = e_eff - int'(man_width);
        wide     = wide_width'(cur_mag);
        q        = '0;
        rem      = '0;
        half     = '0;
        rnd_full = '0;
        if (sh <= 0) begin
            rnd_full = wide << (-sh);
        end else begin
            q    = wide >> sh;
            rem  = wide & ~({wide_width{1'b1}} << sh);
            half = wide_width'(1) << (sh - 1);
            rnd_full = q + (((rem > half) || ((rem == half) && q[0])) ? wide_width'(1) : '0);
        end
        rnd = rnd_full[man_width+1:0];
        fld = 0;
        man = rnd[man_width-1:0];
        if (rnd[man_width+1]) begin
            fld = e_eff - s_int + bias + 1;
            man = '0;
        end else if (rnd[man_width]) begin
            fld = e_eff - s_int + bias;
        end
        if (fld > max_field) begin
            fld = max_field;
            man = '1;
        end
        nonzero = (fld != 0) || (man != '0);
        enc     = {cur[in_width-1] & nonzero, exp_width'(fld), man};
    end

    assign unused_rnd = ^rnd_full[wide_width-1:man_width+2];

    assign o_elem  = (state_q == StEmit) ? enc : '0;
    assign o_last  = (state_q == StEmit) && (idx_q == last_idx);
    assign o_scale = scale_q;

endmodule

// File: tb/tb_mx_quant_fp6.sv
// Directed self-checking bench for mx_quant_fp6 (E2M3, k=32, 16-bit inputs).
module tb_mx_quant_fp6;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [5:0]  o_elem;
    logic [5:0]  o_scale;
    logic        o_valid;
    logic        i_ready;
    logic        o_last;

    int checks = 0;
    int errors = 0;

    logic [15:0] vin [32];
    logic [5:0]  vel [32];

    mx_quant_fp6 dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_elem  (o_elem),
        .o_scale (o_scale),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_vectors();
        foreach (vin[i]) begin
            vin[i] = 16'h0000;
            vel[i] = 6'h00;
        end
    endtask

    // Called at posedge+1 in FILL; returns at posedge+1 after the accept of element 31.
    task automatic send_block();
        for (int i = 0; i < 32; i++) begin
            i_data  = vin[i];
            i_valid = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_data  = 16'h0000;
    endtask

    task automatic recv_block(input logic [5:0] exp_scale, input bit bp);
        int n   = 0;
        int cyc = 0;
        bit hs;
        chk("valid_low_in_scale", o_valid, 1'b0);
        chk("ready_low_in_scale", o_ready, 1'b0);
        @(posedge i_clk);
        #1;
        chk("valid_latency", o_valid, 1'b1);
        while (n < 32 && cyc < 2000) begin
            i_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
            chk($sformatf("elem%0d", n), o_elem, vel[n]);
            chk("scale", o_scale, exp_scale);
            chk($sformatf("last%0d", n), o_last, (n == 31));
            chk("ready_in_emit", o_ready, 1'b0);
            chk("valid_in_emit", o_valid, 1'b1);
            hs = i_ready;
            @(posedge i_clk);
            #1;
            cyc++;
            if (hs) n++;
        end
        i_ready = 1'b0;
        chk("emit_count", n, 32);
        chk("ready_after_block", o_ready, 1'b1);
        chk("valid_after_block", o_valid, 1'b0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = 16'h0000;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_scale", o_scale, 6'd0);
        chk("rst_last", o_last, 1'b0);
        chk("rst_elem", o_elem, 6'd0);

        // Partial block of large values, then reset: must leave no trace in the next block.
        for (int i = 0; i < 10; i++) begin
            i_data  = 16'd16000;
            i_valid = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        chk("midrst_ready", o_ready, 1'b1);
        chk("midrst_valid", o_valid, 1'b0);

        // Basic block: max 96 -> s=4.
        clear_vectors();
        vin[0] = 16'd96;   vel[0] = 6'h1C;
        vin[1] = 16'hFFF0; vel[1] = 6'h28;
        vin[2] = 16'd3;    vel[2] = 6'h02;
        vin[3] = 16'd5;    vel[3] = 6'h02;
        vin[4] = 16'd94;   vel[4] = 6'h1C;
        send_block();
        recv_block(6'd4, 1'b0);

        // Saturation to max normal.
        clear_vectors();
        vin[0] = 16'd127;  vel[0] = 6'h1F;
        vin[1] = 16'hFF81; vel[1] = 6'h3F;
        send_block();
        recv_block(6'd4, 1'b0);

        // All-zero block.
        clear_vectors();
        send_block();
        recv_block(6'd0, 1'b0);

        // Tiny negative rounds to +0.
        clear_vectors();
        vin[0] = 16'd96;   vel[0] = 6'h1C;
        vin[5] = 16'hFFFF; vel[5] = 6'h00;
        send_block();
        recv_block(6'd4, 1'b0);

        // Most negative input.
        clear_vectors();
        vin[0] = 16'h8000; vel[0] = 6'h38;
        send_block();
        recv_block(6'd13, 1'b0);

        // Backpressure, with rounding carries (subnormal->normal, exponent bump).
        clear_vectors();
        vin[0]  = 16'd96;   vel[0]  = 6'h1C;
        vin[1]  = 16'hFFF0; vel[1]  = 6'h28;
        vin[2]  = 16'd3;    vel[2]  = 6'h02;
        vin[3]  = 16'd5;    vel[3]  = 6'h02;
        vin[4]  = 16'd94;   vel[4]  = 6'h1C;
        vin[10] = 16'd7;    vel[10] = 6'h04;
        vin[20] = 16'd9;    vel[20] = 6'h04;
        vin[25] = 16'd31;   vel[25] = 6'h10;
        vin[26] = 16'd15;   vel[26] = 6'h08;
        vin[31] = 16'hFFD0; vel[31] = 6'h34;
        send_block();
        recv_block(6'd4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
